// File: rtl/md_sequencer.sv
// md_sequencer
// Multicycle multiply/divide controller that sits beside the execute-stage
// ALU. One operation runs at a time with a fixed latency: the accepting
// cycle, one PREP cycle, WIDTH CALC cycles and one FIX cycle, followed by a
// DONE cycle in which the new HI/LO values are visible and done pulses.
//
// Ports:
//   CLK    system clock, all state on the rising edge
//   RST    asynchronous active-high reset
//   start  request a new operation (sampled only in IDLE)
//   op     0=MULTU, 1=MULT, 2=DIVU, 3=DIV (latched with start)
//   porta  multiplicand / dividend (latched with start)
//   portb  multiplier / divisor (latched with start)
//   flush  pipeline flush, aborts an operation before DONE
//   busy   execute freeze request (combinational)
//   done   one-cycle pulse, HI/LO updated this cycle
//   hi     product high half / remainder
//   lo     product low half / quotient

module md_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] porta,
  input  logic [WIDTH-1:0] portb,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t               state;
  logic [1:0]           op_r;
  logic [WIDTH-1:0]     a_r;
  logic [WIDTH-1:0]     b_r;
  logic [WIDTH-1:0]     m_r;
  logic [2*WIDTH-1:0]   acc;
  logic [CW-1:0]        count;
  logic                 neg_a;
  logic                 neg_b;

  logic                 is_div;
  logic                 is_signed;
  logic [WIDTH-1:0]     mag_a;
  logic [WIDTH-1:0]     mag_b;
  logic [WIDTH:0]       add_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       shifted;
  logic [WIDTH+1:0]     trial;
  logic [2*WIDTH-1:0]   div_next;
  logic [2*WIDTH-1:0]   neg_acc;
  logic [WIDTH-1:0]     fix_hi;
  logic [WIDTH-1:0]     fix_lo;

  assign is_div    = op_r[1];
  assign is_signed = op_r[0];

  // Freeze execute in the same cycle a start is accepted; release on DONE.
  assign busy = (state == PREP) || (state == CALC) || (state == FIX) ||
                ((state == IDLE) && start && !flush);

  // Operand magnitudes for the signed ops; the most negative value maps to
  // itself, which is its correct unsigned magnitude.
  always_comb begin
    mag_a = a_r;
    mag_b = b_r;
    if (is_signed && a_r[WIDTH-1]) mag_a = -a_r;
    if (is_signed && b_r[WIDTH-1]) mag_b = -b_r;
  end

  // Shift-add multiply step. The accumulator holds {partial product,
  // remaining multiplier bits}; the carry out of the adder becomes the new
  // top bit after the right shift.
  always_comb begin
    add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, m_r};
    mul_next = {1'b0, acc[2*WIDTH-1:1]};
    if (acc[0]) mul_next = {add_sum, acc[WIDTH-1:1]};
  end

  // Restoring divide step on {rem, quot}. The shifted remainder can need
  // WIDTH+1 bits, so the trial subtraction keeps one extra bit for borrow.
  always_comb begin
    shifted  = acc[2*WIDTH-1:WIDTH-1];
    trial    = {1'b0, shifted} - {2'b00, m_r};
    div_next = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    if (!trial[WIDTH+1]) div_next = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  end

  // Sign correction of the final result. A zero divisor overrides the
  // iterated result with the fixed all-ones quotient and the raw dividend.
  always_comb begin
    neg_acc = -acc;
    fix_hi  = acc[2*WIDTH-1:WIDTH];
    fix_lo  = acc[WIDTH-1:0];
    if (!is_div) begin
      if (neg_a ^ neg_b) begin
        fix_hi = neg_acc[2*WIDTH-1:WIDTH];
        fix_lo = neg_acc[WIDTH-1:0];
      end
    end else if (b_r == '0) begin
      fix_hi = a_r;
      fix_lo = '1;
    end else begin
      if (neg_a ^ neg_b) fix_lo = -acc[WIDTH-1:0];
      if (neg_a)         fix_hi = -acc[2*WIDTH-1:WIDTH];
    end
  end

  // Sequencer. HI/LO are loaded on the edge into DONE so the new values are
  // visible together with the done pulse; a flush sampled in DONE therefore
  // cannot cancel the update.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      op_r  <= '0;
      a_r   <= '0;
      b_r   <= '0;
      m_r   <= '0;
      acc   <= '0;
      count <= '0;
      neg_a <= 1'b0;
      neg_b <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !flush) begin
            op_r  <= op;
            a_r   <= porta;
            b_r   <= portb;
            state <= PREP;
          end
        end
        PREP: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            neg_a <= is_signed & a_r[WIDTH-1];
            neg_b <= is_signed & b_r[WIDTH-1];
            count <= CW'(WIDTH);
            if (is_div) begin
              acc <= {{WIDTH{1'b0}}, mag_a};
              m_r <= mag_b;
            end else begin
              acc <= {{WIDTH{1'b0}}, mag_b};
              m_r <= mag_a;
            end
            state <= CALC;
          end
        end
        CALC: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            acc   <= is_div ? div_next : mul_next;
            count <= count - 1'b1;
            if (count == CW'(1)) state <= FIX;
          end
        end
        FIX: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            hi    <= fix_hi;
            lo    <= fix_lo;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md_sequencer.sv
// tb_md_sequencer
// Self-checking bench for md_sequencer (WIDTH=32). Expected HI/LO values
// come from a reference model using plain 64-bit arithmetic; busy/done are
// checked cycle by cycle against the fixed-latency timeline.

module tb_md_sequencer;

  logic        CLK;
  logic        RST;
  logic        start;
  logic [1:0]  op;
  logic [31:0] porta;
  logic [31:0] portb;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks;
  int fails;
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  md_sequencer #(.WIDTH(32)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .start (start),
    .op    (op),
    .porta (porta),
    .portb (portb),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model returning {hi, lo}.
  function automatic logic [63:0] model(input logic [1:0] o,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa;
    longint sb;
    longint q;
    longint r;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    res = '0;
    case (o)
      2'd0: res = {32'd0, a} * {32'd0, b};
      2'd1: res = 64'(sa * sb);
      default: begin
        if (b == 32'd0) begin
          res = {a, 32'hFFFF_FFFF};
        end else if (o == 2'd2) begin
          res = {a % b, a / b};
        end else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
    endcase
    return res;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got,
                             input logic [63:0] expected);
    checks++;
    if (got !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, expected, $time);
    end
  endtask

  // Runs one operation from the accepting cycle (0) through DONE (35).
  // flush_cyc/rst_cyc < 0 disables that event; noise scrambles the inputs
  // (including spurious starts) while the operation is in flight.
  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a,
                               input logic [31:0] b, input int flush_cyc,
                               input int rst_cyc, input bit noise,
                               input bit start_in_done);
    logic [63:0] res;
    bit aborted;
    res = model(o, a, b);
    aborted = 1'b0;
    @(negedge CLK);
    start = 1'b1; op = o; porta = a; portb = b; flush = 1'b0;
    #1;
    checkOutput("busy_c0", 64'(busy), 64'd1);
    checkOutput("done_c0", 64'(done), 64'd0);
    for (int cyc = 1; cyc <= 35; cyc++) begin
      @(negedge CLK);
      start = 1'b0;
      if (noise && cyc < 35) begin
        start = 1'($urandom_range(0, 1));
        op    = 2'($urandom);
        porta = $urandom;
        portb = $urandom;
      end
      if (start_in_done && cyc == 35) start = 1'b1;
      flush = (cyc == flush_cyc);
      if (cyc == rst_cyc) begin
        RST = 1'b1;
        #1;
        checkOutput("rst_hi", 64'(hi), 64'd0);
        checkOutput("rst_lo", 64'(lo), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        exp_hi = '0;
        exp_lo = '0;
        @(negedge CLK);
        RST = 1'b0;
        #1;
        checkOutput("post_rst_busy", 64'(busy), 64'd0);
        return;
      end
      #1;
      if (flush_cyc >= 1 && flush_cyc < 35 && cyc > flush_cyc) begin
        aborted = 1'b1;
        checkOutput("abort_busy", 64'(busy), 64'd0);
        checkOutput("abort_done", 64'(done), 64'd0);
        checkOutput("abort_hilo", {hi, lo}, {exp_hi, exp_lo});
      end else begin
        checkOutput("busy", 64'(busy), 64'(cyc <= 34));
        checkOutput("done", 64'(done), 64'(cyc == 35));
        if (cyc == 35) begin
          checkOutput("result", {hi, lo}, res);
          exp_hi = res[63:32];
          exp_lo = res[31:0];
        end else if (cyc < 35) begin
          checkOutput("hold_hilo", {hi, lo}, {exp_hi, exp_lo});
        end
      end
    end
    if (aborted) begin
      for (int k = 0; k < 5; k++) begin
        @(negedge CLK);
        flush = 1'b0;
        #1;
        checkOutput("idle_done", 64'(done), 64'd0);
        checkOutput("idle_hilo", {hi, lo}, {exp_hi, exp_lo});
      end
    end
    if (start_in_done || flush_cyc == 35) begin
      @(negedge CLK);
      start = 1'b0;
      flush = 1'b0;
      #1;
      checkOutput("after_done_busy", 64'(busy), 64'd0);
      checkOutput("after_done_done", 64'(done), 64'd0);
      checkOutput("after_done_hilo", {hi, lo}, {exp_hi, exp_lo});
    end
    start = 1'b0;
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    checks = 0;
    fails  = 0;
    exp_hi = '0;
    exp_lo = '0;
    RST = 1'b1; start = 1'b0; op = '0; porta = '0; portb = '0; flush = 1'b0;
    repeat (3) @(negedge CLK);
    #1;
    checkOutput("reset_hi", 64'(hi), 64'd0);
    checkOutput("reset_lo", 64'(lo), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    @(negedge CLK);
    RST = 1'b0;

    $display("[TB] directed operations");
    applyStimulus(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1, 1'b0, 1'b0);
    applyStimulus(2'd1, 32'hFFFF_FFFD, 32'd7, -1, -1, 1'b0, 1'b0);
    applyStimulus(2'd3, 32'hFFFF_FFF9, 32'd2, -1, -1, 1'b0, 1'b0);
    applyStimulus(2'd2, 32'd7, 32'd2, -1, -1, 1'b0, 1'b0);
    applyStimulus(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1, 1'b0, 1'b0);
    applyStimulus(2'd2, 32'd5, 32'd0, -1, -1, 1'b0, 1'b0);
    applyStimulus(2'd3, 32'hFFFF_FFFB, 32'd0, -1, -1, 1'b0, 1'b0);

    $display("[TB] flush, start-with-flush, reset and ignored starts");
    applyStimulus(2'd0, 32'h1234_5678, 32'd1, -1, -1, 1'b0, 1'b0);
    applyStimulus(2'd0, 32'd3, 32'd4, 10, -1, 1'b0, 1'b0);
    applyStimulus(2'd1, 32'd9, 32'd9, 34, -1, 1'b0, 1'b0);
    applyStimulus(2'd2, 32'd100, 32'd7, 35, -1, 1'b0, 1'b0);

    @(negedge CLK);
    start = 1'b1; flush = 1'b1; op = 2'd0; porta = 32'd6; portb = 32'd6;
    #1;
    checkOutput("start_flush_busy", 64'(busy), 64'd0);
    @(negedge CLK);
    start = 1'b0; flush = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      #1;
      checkOutput("start_flush_idle", {31'd0, busy, 31'd0, done}, 64'd0);
    end
    checkOutput("start_flush_hilo", {hi, lo}, {exp_hi, exp_lo});

    applyStimulus(2'd2, 32'hDEAD_BEEF, 32'd13, -1, 20, 1'b0, 1'b0);
    applyStimulus(2'd1, 32'hFFFF_FF00, 32'h0000_0123, -1, -1, 1'b1, 1'b0);
    applyStimulus(2'd3, 32'd1000, 32'hFFFF_FFF9, -1, -1, 1'b0, 1'b1);

    $display("[TB] randomized operations");
    for (int n = 0; n < 24; n++) begin
      ro = 2'($urandom);
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = $urandom_range(1, 15);
        2: ra = 32'h8000_0000;
        3: rb = -($urandom_range(1, 15));
        default: ;
      endcase
      applyStimulus(ro, ra, rb, -1, -1, 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
